// File: rtl/cont_rw_regs_pkg.sv
// rtl/cont_rw_regs_pkg.sv - shared FSM encoding and elaboration helpers for the auto-increment register file
package cont_rw_regs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cont_rw_autoinc_regs_autoinc_ptr.sv
// rtl/cont_rw_autoinc_regs_autoinc_ptr.sv - register pointer with load, advance, wrap/saturate and range flag
module autoinc_ptr
    import cont_rw_regs_pkg::*;
#(
    parameter int NUM_REGS = 48,
    parameter int ADDR_W   = 6,
    parameter int WRAP_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              advance,
    output logic [ADDR_W-1:0] ptr,
    output logic              in_range
);

    localparam logic [ADDR_W:0]   NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(NUM_REGS - 1);

    if (clog2(NUM_REGS) > ADDR_W) begin : g_addr_w_check
        $error("ADDR_W too narrow for NUM_REGS");
    end

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    always_comb begin
        in_range = ({1'b0, ptr_q} < NUM_REGS_EXT);
        ptr_d    = ptr_q;
        if (load) begin
            ptr_d = load_val;
        end else if (advance && in_range) begin
            // An out-of-range pointer is parked until the next load.
            if (ptr_q == LAST_IDX) begin
                ptr_d = (WRAP_EN != 0) ? '0 : LAST_IDX;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/cont_rw_autoinc_regs.sv
// rtl/cont_rw_autoinc_regs.sv - byte register file with auto-incrementing pointer and mixed RW/RO registers
module cont_rw_autoinc_regs
    import cont_rw_regs_pkg::*;
#(
    parameter int                         NUM_REGS = 48,
    parameter int                         DATA_W   = 8,
    parameter int                         ADDR_W   = 6,
    parameter logic [NUM_REGS-1:0]        WR_MASK  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL  = '0,
    parameter int                         WRAP_EN  = 1
) (
    input  logic                         iClk,
    input  logic                         iRst_n,
    input  logic                         iAddrLoad,
    input  logic [ADDR_W-1:0]            ivAddress,
    input  logic                         iRdReq,
    input  logic                         iWrReq,
    input  logic [DATA_W-1:0]            ivWrData,
    input  logic [NUM_REGS*DATA_W-1:0]   ivRoData,
    output logic [DATA_W-1:0]            ovQ,
    output logic                         oAccessDone,
    output logic [ADDR_W-1:0]            ovPointer,
    output logic [NUM_REGS*DATA_W-1:0]   ovRwRegs,
    output logic [NUM_REGS-1:0]          oWrStb,
    output logic                         oErr
);

    // Read-only slots are held at zero so ovRwRegs can be driven straight from storage.
    function automatic logic [NUM_REGS*DATA_W-1:0] masked_rst();
        logic [NUM_REGS*DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (WR_MASK[i]) r[i*DATA_W +: DATA_W] = RST_VAL[i*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    localparam logic [NUM_REGS*DATA_W-1:0] RST_EFF = masked_rst();

    state_e                     state_q, state_d;
    logic [DATA_W-1:0]          q_q, q_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic [NUM_REGS-1:0]        wr_stb_q, wr_stb_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;

    logic                       ptr_load;
    logic                       ptr_adv;
    logic                       ptr_in_range;
    logic [ADDR_W-1:0]          ptr;
    logic [NUM_REGS-1:0]        ptr_hit;
    logic                       ptr_writable;
    logic [DATA_W-1:0]          rd_val;
    logic                       wr_en;

    autoinc_ptr #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .WRAP_EN  (WRAP_EN)
    ) u_ptr (
        .clk      (iClk),
        .rst_n    (iRst_n),
        .load     (ptr_load),
        .load_val (ivAddress),
        .advance  (ptr_adv),
        .ptr      (ptr),
        .in_range (ptr_in_range)
    );

    always_comb begin
        ptr_hit      = '0;
        ptr_writable = 1'b0;
        rd_val       = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ptr == ADDR_W'(i)) begin
                ptr_hit[i]   = 1'b1;
                ptr_writable = WR_MASK[i];
                rd_val       = WR_MASK[i] ? regs_q[i*DATA_W +: DATA_W]
                                          : ivRoData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        done_d   = (state_q == ST_CAPTURE);
        err_d    = err_q;
        wr_stb_d = '0;
        regs_d   = regs_q;
        ptr_load = 1'b0;
        ptr_adv  = 1'b0;
        wr_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iAddrLoad) begin
                    ptr_load = 1'b1;
                    err_d    = 1'b0;
                end else if (iWrReq) begin
                    state_d = ST_CAPTURE;
                    ptr_adv = 1'b1;
                    wr_en   = ptr_writable;
                    if (iRdReq || !ptr_writable) err_d = 1'b1;
                end else if (iRdReq) begin
                    state_d = ST_CAPTURE;
                    ptr_adv = 1'b1;
                    q_d     = rd_val;
                    if (!ptr_in_range) err_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_DONE;
                if (iAddrLoad || iRdReq || iWrReq) err_d = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (iAddrLoad || iRdReq || iWrReq) err_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_en) wr_stb_d = ptr_hit;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && ptr_hit[i]) regs_d[i*DATA_W +: DATA_W] = ivWrData;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q  <= ST_IDLE;
            q_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wr_stb_q <= '0;
            regs_q   <= RST_EFF;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wr_stb_q <= wr_stb_d;
            regs_q   <= regs_d;
        end
    end

    assign ovQ         = q_q;
    assign oAccessDone = done_q;
    assign ovPointer   = ptr;
    assign ovRwRegs    = regs_q;
    assign oWrStb      = wr_stb_q;
    assign oErr        = err_q;

endmodule

// File: tb/tb_cont_rw_autoinc_regs.sv
// tb/tb_cont_rw_autoinc_regs.sv - scoreboard bench: wrapping DUT (index 0) and saturating DUT (index 1)
module tb_cont_rw_autoinc_regs;

    localparam int NR = 48;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam logic [NR-1:0]    MASK_A = 48'h0000_000F_0000;
    localparam logic [NR*DW-1:0] RST_A  = (384'h3C << (18 * 8)) | (384'hEE << (5 * 8));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n     [2];
    logic             addr_load [2];
    logic [AW-1:0]    addr      [2];
    logic             rd_req    [2];
    logic             wr_req    [2];
    logic [DW-1:0]    wr_data   [2];
    logic [NR*DW-1:0] ro_data;

    logic [DW-1:0]    q         [2];
    logic             done      [2];
    logic [AW-1:0]    ptr       [2];
    logic [NR*DW-1:0] rw_regs   [2];
    logic [NR-1:0]    wr_stb    [2];
    logic             err       [2];

    cont_rw_autoinc_regs #(
        .NUM_REGS (NR), .DATA_W (DW), .ADDR_W (AW),
        .WR_MASK  (MASK_A), .RST_VAL (RST_A), .WRAP_EN (1)
    ) u_dut_a (
        .iClk (clk), .iRst_n (rst_n[0]), .iAddrLoad (addr_load[0]), .ivAddress (addr[0]),
        .iRdReq (rd_req[0]), .iWrReq (wr_req[0]), .ivWrData (wr_data[0]), .ivRoData (ro_data),
        .ovQ (q[0]), .oAccessDone (done[0]), .ovPointer (ptr[0]), .ovRwRegs (rw_regs[0]),
        .oWrStb (wr_stb[0]), .oErr (err[0])
    );

    cont_rw_autoinc_regs #(
        .NUM_REGS (NR), .DATA_W (DW), .ADDR_W (AW), .WRAP_EN (0)
    ) u_dut_b (
        .iClk (clk), .iRst_n (rst_n[1]), .iAddrLoad (addr_load[1]), .ivAddress (addr[1]),
        .iRdReq (rd_req[1]), .iWrReq (wr_req[1]), .ivWrData (wr_data[1]), .ivRoData (ro_data),
        .ovQ (q[1]), .oAccessDone (done[1]), .ovPointer (ptr[1]), .ovRwRegs (rw_regs[1]),
        .oWrStb (wr_stb[1]), .oErr (err[1])
    );

    typedef struct {
        logic [DW-1:0] q;
        logic          chk_q;
        logic [AW-1:0] ptr;
        logic          err;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   stb_a[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_unexpected(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=0x%0h required=none", name, act);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   ix;
        if (done[0] === 1'b1) begin
            if (exp_a.size() == 0) fail_unexpected("a_done_pulse", 64'(done[0]));
            else begin
                e = exp_a.pop_front();
                if (e.chk_q) chk("a_q", 64'(q[0]), 64'(e.q));
                chk("a_ptr", 64'(ptr[0]), 64'(e.ptr));
                chk("a_err", 64'(err[0]), 64'(e.err));
            end
        end
        if (wr_stb[0] !== '0) begin
            if (stb_a.size() == 0) fail_unexpected("a_wrstb_pulse", 64'(wr_stb[0]));
            else begin
                ix = stb_a.pop_front();
                chk("a_wrstb", 64'(wr_stb[0]), 64'(1) << ix);
            end
        end
        if (done[1] === 1'b1) begin
            if (exp_b.size() == 0) fail_unexpected("b_done_pulse", 64'(done[1]));
            else begin
                e = exp_b.pop_front();
                if (e.chk_q) chk("b_q", 64'(q[1]), 64'(e.q));
                chk("b_ptr", 64'(ptr[1]), 64'(e.ptr));
                chk("b_err", 64'(err[1]), 64'(e.err));
            end
        end
        if (wr_stb[1] !== '0) fail_unexpected("b_wrstb_pulse", 64'(wr_stb[1]));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int s, input logic [AW-1:0] a);
        addr_load[s] = 1'b1;
        addr[s]      = a;
        cyc();
        addr_load[s] = 1'b0;
    endtask

    task automatic access(input int s, input logic rd, input logic wr, input logic [DW-1:0] d);
        rd_req[s]  = rd;
        wr_req[s]  = wr;
        wr_data[s] = d;
        cyc();
        rd_req[s] = 1'b0;
        wr_req[s] = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic expect_done(input int s, input logic [DW-1:0] eq, input logic cq,
                               input logic [AW-1:0] ep, input logic ee);
        exp_t x;
        x.q = eq; x.chk_q = cq; x.ptr = ep; x.err = ee;
        if (s == 0) exp_a.push_back(x);
        else        exp_b.push_back(x);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) ro_data[i*DW +: DW] = DW'(i);
        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b0; addr_load[s] = 1'b0; addr[s] = '0;
            rd_req[s] = 1'b0; wr_req[s] = 1'b0; wr_data[s] = '0;
        end
        cyc(); cyc(); cyc();

        chk("rst_q", 64'(q[0]), 64'h0);
        chk("rst_ptr", 64'(ptr[0]), 64'h0);
        chk("rst_err", 64'(err[0]), 64'h0);
        chk("rst_done", 64'(done[0]), 64'h0);
        chk("rst_wrstb", 64'(wr_stb[0]), 64'h0);
        chk("rst_rw12", 64'(rw_regs[0][18*8 +: 8]), 64'h3C);
        chk("rst_ro05_zero", 64'(rw_regs[0][5*8 +: 8]), 64'h0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        cyc();

        // wrap through the top of the map
        load(0, 6'h2E);
        expect_done(0, 8'h2E, 1, 6'h2F, 0); access(0, 1, 0, 8'h00);
        expect_done(0, 8'h2F, 1, 6'h00, 0); access(0, 1, 0, 8'h00);
        expect_done(0, 8'h00, 1, 6'h01, 0); access(0, 1, 0, 8'h00);
        chk("wrap_ptr", 64'(ptr[0]), 64'h01);
        chk("wrap_err", 64'(err[0]), 64'h0);

        load(0, 6'h12);
        expect_done(0, 8'h3C, 1, 6'h13, 0); access(0, 1, 0, 8'h00);

        // writable registers
        load(0, 6'h10);
        stb_a.push_back(16); expect_done(0, 8'h00, 0, 6'h11, 0); access(0, 0, 1, 8'hA5);
        stb_a.push_back(17); expect_done(0, 8'h00, 0, 6'h12, 0); access(0, 0, 1, 8'h5A);
        chk("rw10", 64'(rw_regs[0][16*8 +: 8]), 64'hA5);
        chk("rw11", 64'(rw_regs[0][17*8 +: 8]), 64'h5A);
        load(0, 6'h10);
        expect_done(0, 8'hA5, 1, 6'h11, 0); access(0, 1, 0, 8'h00);
        expect_done(0, 8'h5A, 1, 6'h12, 0); access(0, 1, 0, 8'h00);

        // write to read-only register
        load(0, 6'h05);
        expect_done(0, 8'h00, 0, 6'h06, 1); access(0, 0, 1, 8'h77);
        chk("ro05_unchanged", 64'(rw_regs[0][5*8 +: 8]), 64'h0);
        chk("ro_err_sticky", 64'(err[0]), 64'h1);
        load(0, 6'h00);
        chk("load_clears_err", 64'(err[0]), 64'h0);

        // out-of-range write parks the pointer
        load(0, 6'h3F);
        expect_done(0, 8'h00, 0, 6'h3F, 1); access(0, 0, 1, 8'h11);
        chk("oor_ptr_parked", 64'(ptr[0]), 64'h3F);

        // request while busy is dropped
        load(0, 6'h01);
        expect_done(0, 8'h01, 1, 6'h02, 1);
        rd_req[0] = 1'b1;
        cyc();
        cyc();
        rd_req[0] = 1'b0;
        cyc();
        cyc();
        chk("busy_ptr", 64'(ptr[0]), 64'h02);
        chk("busy_err", 64'(err[0]), 64'h1);

        // simultaneous read and write behaves as a write
        load(0, 6'h13);
        stb_a.push_back(19); expect_done(0, 8'h01, 1, 6'h14, 1); access(0, 1, 1, 8'h99);
        chk("rw13", 64'(rw_regs[0][19*8 +: 8]), 64'h99);

        // reset in the middle of an access
        load(0, 6'h20);
        rd_req[0] = 1'b1;
        cyc();
        rd_req[0] = 1'b0;
        rst_n[0]  = 1'b0;
        cyc();
        chk("midrst_q", 64'(q[0]), 64'h0);
        chk("midrst_ptr", 64'(ptr[0]), 64'h0);
        chk("midrst_err", 64'(err[0]), 64'h0);
        chk("midrst_done", 64'(done[0]), 64'h0);
        chk("midrst_rw10", 64'(rw_regs[0][16*8 +: 8]), 64'h0);
        chk("midrst_rw13", 64'(rw_regs[0][19*8 +: 8]), 64'h0);
        rst_n[0] = 1'b1;
        cyc(); cyc(); cyc(); cyc();

        // saturating pointer
        load(1, 6'h2F);
        expect_done(1, 8'h2F, 1, 6'h2F, 0); access(1, 1, 0, 8'h00);
        expect_done(1, 8'h2F, 1, 6'h2F, 0); access(1, 1, 0, 8'h00);
        chk("sat_ptr", 64'(ptr[1]), 64'h2F);
        load(1, 6'h3F);
        expect_done(1, 8'h00, 1, 6'h3F, 1); access(1, 1, 0, 8'h00);

        cyc();
        chk("a_pending_done", 64'(exp_a.size()), 64'h0);
        chk("b_pending_done", 64'(exp_b.size()), 64'h0);
        chk("a_pending_wrstb", 64'(stb_a.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
